// File: rtl/dnn_result_pkg.sv
// dnn_result_pkg: shared FSM state type and default sizing for the DNN result argmax block
//   state_t             : IDLE / SCAN / DONE
//   DNN_DATA_WIDTH      : default signed score width
//   DNN_NUM_CLASSES     : default number of class scores
//   DNN_IDX_WIDTH       : default class index width
package dnn_result_pkg;

    localparam int DNN_DATA_WIDTH  = 10;
    localparam int DNN_NUM_CLASSES = 10;
    localparam int DNN_IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/dnn_result_argmax.sv
// dnn_result_argmax: captures a bank of signed class scores and scans it serially for the argmax
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : one-cycle pulse, in_scores valid (ignored while scanning, flags overrun)
//   in_scores  : NUM_CLASSES signed scores, element k belongs to class k
//   clear      : drops a finished result (ignored by the FSM mid-scan), always clears overrun
//   rd_idx     : bank readout index; out-of-range reads return class 0
//   rd_data    : registered bank[rd_idx], one cycle latency
//   busy       : high while scanning
//   res_valid  : result final; res_idx / res_max hold argmax and max score
//   overrun    : sticky, in_valid arrived during a scan
module dnn_result_argmax
    import dnn_result_pkg::*;
#(
    parameter int DATA_WIDTH  = DNN_DATA_WIDTH,
    parameter int NUM_CLASSES = DNN_NUM_CLASSES,
    parameter int IDX_WIDTH   = DNN_IDX_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]      in_scores,
    input  logic                                        clear,
    input  logic [IDX_WIDTH-1:0]                        rd_idx,
    output logic signed [DATA_WIDTH-1:0]                rd_data,
    output logic                                        busy,
    output logic                                        res_valid,
    output logic [IDX_WIDTH-1:0]                        res_idx,
    output logic signed [DATA_WIDTH-1:0]                res_max,
    output logic                                        overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH:0]   NC_EXT   = (IDX_WIDTH + 1)'(NUM_CLASSES);

    state_t                         r_state;
    logic signed [DATA_WIDTH-1:0]   r_bank [NUM_CLASSES];
    logic [IDX_WIDTH-1:0]           r_ptr;
    logic signed [DATA_WIDTH-1:0]   r_cur_max;
    logic [IDX_WIDTH-1:0]           r_cur_idx;
    logic signed [DATA_WIDTH-1:0]   r_rd_data;
    logic                           r_busy;
    logic                           r_res_valid;
    logic [IDX_WIDTH-1:0]           r_res_idx;
    logic signed [DATA_WIDTH-1:0]   r_res_max;
    logic                           r_overrun;

    logic                           w_gt;
    logic                           w_rd_ok;
    logic signed [DATA_WIDTH-1:0]   w_next_max;
    logic [IDX_WIDTH-1:0]           w_next_idx;

    // strict greater-than so that a tie keeps the earlier (lower) index
    assign w_gt       = r_bank[r_ptr] > r_cur_max;
    assign w_next_max = w_gt ? r_bank[r_ptr] : r_cur_max;
    assign w_next_idx = w_gt ? r_ptr : r_cur_idx;
    assign w_rd_ok    = {1'b0, rd_idx} < NC_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bank      <= '{default: '0};
            r_ptr       <= '0;
            r_cur_max   <= '0;
            r_cur_idx   <= '0;
            r_rd_data   <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_max   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_rd_data <= w_rd_ok ? r_bank[rd_idx] : r_bank[0];
            if (clear)
                r_overrun <= 1'b0;
            else if (in_valid && r_state == SCAN)
                r_overrun <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    // a new capture takes precedence over a simultaneous clear
                    if (in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++)
                            r_bank[k] <= in_scores[k];
                        r_cur_max   <= in_scores[0];
                        r_cur_idx   <= '0;
                        r_ptr       <= IDX_WIDTH'(1);
                        r_busy      <= 1'b1;
                        r_res_valid <= 1'b0;
                        r_state     <= SCAN;
                    end else if (clear && r_state == DONE) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                SCAN: begin
                    r_cur_max <= w_next_max;
                    r_cur_idx <= w_next_idx;
                    r_ptr     <= r_ptr + 1'b1;
                    if (r_ptr == LAST_IDX) begin
                        r_res_max   <= w_next_max;
                        r_res_idx   <= w_next_idx;
                        r_res_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_ptr       <= '0;
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_max   = r_res_max;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_dnn_result_argmax.sv
// tb_dnn_result_argmax: directed self-checking bench for dnn_result_argmax
module tb_dnn_result_argmax;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [9:0][9:0]        in_scores = '0;
    logic                   clear = 1'b0;
    logic [3:0]             rd_idx = '0;
    logic signed [9:0]      rd_data;
    logic                   busy;
    logic                   res_valid;
    logic [3:0]             res_idx;
    logic signed [9:0]      res_max;
    logic                   overrun;

    int n_chk  = 0;
    int n_pass = 0;

    dnn_result_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_scores (in_scores),
        .clear     (clear),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_max   (res_max),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_scores(input int s[10]);
        for (int k = 0; k < 10; k++)
            in_scores[k] = s[k][9:0];
    endtask

    // called #1 after a rising edge; returns #1 after the capturing edge
    task automatic capture(input int s[10], input logic clr);
        set_scores(s);
        in_valid = 1'b1;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // counts edges after the capture edge until res_valid, plus busy samples before it;
    // optionally injects a second in_valid sampled at edge inj_at
    task automatic wait_done(input int inj_at, input int t[10], output int n, output int nb);
        nb = int'(busy);
        n  = 0;
        for (int i = 1; i <= 20; i++) begin
            if (inj_at == i) begin
                set_scores(t);
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = i;
            if (res_valid)
                break;
            nb += int'(busy);
        end
    endtask

    int a1[10] = '{3, -7, 12, 5, 0, -512, 11, 12, 1, 2};
    int a2[10] = '{-512, -512, -512, -512, -512, -512, -512, -512, -512, -512};
    int a3[10] = '{-512, 100, 510, -1, 0, 5, 510, 7, 8, 511};
    int b1[10] = '{0, 1, 2, 3, 4, 300, 6, 7, 8, 9};
    int b2[10] = '{-5, -3, -3, -9, -1, -1, -20, -7, -2, -8};
    int c1[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    int d1[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    int n_e, n_b;
    bit saw_valid;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_idx", int'(res_idx), 0);
        chk("rst_res_max", int'(res_max), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rd_data", int'(rd_data), 0);

        // basic scan with a tie on the maximum
        capture(a1, 1'b0);
        chk("t1_busy_after_capture", int'(busy), 1);
        wait_done(0, a1, n_e, n_b);
        chk("t1_latency", n_e, 9);
        chk("t1_busy_cycles", n_b, 9);
        chk("t1_busy_done", int'(busy), 0);
        chk("t1_res_idx", int'(res_idx), 2);
        chk("t1_res_max", int'(res_max), 12);

        // all minimum scores, started from DONE
        capture(a2, 1'b0);
        chk("t2_res_valid_drop", int'(res_valid), 0);
        wait_done(0, a1, n_e, n_b);
        chk("t2_latency", n_e, 9);
        chk("t2_res_idx", int'(res_idx), 0);
        chk("t2_res_max", int'(res_max), -512);

        // maximum positive score in the last class
        capture(a3, 1'b0);
        wait_done(0, a1, n_e, n_b);
        chk("t3_latency", n_e, 9);
        chk("t3_res_idx", int'(res_idx), 9);
        chk("t3_res_max", int'(res_max), 511);

        // readout sweep including out-of-range indices
        for (int k = 0; k < 16; k++) begin
            rd_idx = 4'(k);
            @(posedge clk);
            #1;
            chk($sformatf("rd_%0d", k), int'(rd_data), k < 10 ? a3[k] : a3[0]);
        end
        chk("t3_res_idx_hold", int'(res_idx), 9);

        // second in_valid mid-scan is ignored but flags overrun
        capture(a1, 1'b0);
        wait_done(4, b1, n_e, n_b);
        chk("ov_latency", n_e, 9);
        chk("ov_res_idx", int'(res_idx), 2);
        chk("ov_res_max", int'(res_max), 12);
        chk("ov_overrun", int'(overrun), 1);
        rd_idx = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("ov_bank5", int'(rd_data), -512);
        chk("ov_overrun_sticky", int'(overrun), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_res_valid", int'(res_valid), 0);
        chk("clr_overrun", int'(overrun), 0);
        chk("clr_res_idx_hold", int'(res_idx), 2);

        // reset at scan cycle 5 aborts the scan
        capture(a1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ar_res_valid", int'(res_valid), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_res_idx", int'(res_idx), 0);
        chk("ar_res_max", int'(res_max), 0);
        chk("ar_overrun", int'(overrun), 0);
        chk("ar_rd_data", int'(rd_data), 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (res_valid)
                saw_valid = 1'b1;
        end
        chk("ar_no_res_valid", int'(saw_valid), 0);
        capture(b2, 1'b0);
        wait_done(0, a1, n_e, n_b);
        chk("ar_new_latency", n_e, 9);
        chk("ar_new_res_idx", int'(res_idx), 4);
        chk("ar_new_res_max", int'(res_max), -1);

        // clear and in_valid together in DONE
        capture(c1, 1'b0);
        wait_done(2, a1, n_e, n_b);
        chk("cv_first_idx", int'(res_idx), 0);
        chk("cv_first_max", int'(res_max), 0);
        chk("cv_first_overrun", int'(overrun), 1);
        capture(d1, 1'b1);
        chk("cv_res_valid", int'(res_valid), 0);
        chk("cv_busy", int'(busy), 1);
        chk("cv_overrun", int'(overrun), 0);
        wait_done(0, a1, n_e, n_b);
        chk("cv_latency", n_e, 9);
        chk("cv_res_idx", int'(res_idx), 9);
        chk("cv_res_max", int'(res_max), 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
